// File: rtl/jpeg_pkg.sv
// Shared encodings for the JPEG MCU double-buffer bank controller:
// bank occupancy states, reader FSM states and block coordinate width.
package jpeg_pkg;

    localparam int BLOCK_COORD_W = 12;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_BUSY = 2'd2
    } rd_state_t;

endpackage

// File: rtl/jpeg_bank_slot.sv
// One buffer bank: occupancy state plus the MCU coordinates of the block it holds.
module jpeg_bank_slot
    import jpeg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [BLOCK_COORD_W-1:0] i_x,
    input  logic [BLOCK_COORD_W-1:0] i_y,
    input  logic                     i_start,
    input  logic                     i_release,
    output bank_state_t              o_state,
    output logic [BLOCK_COORD_W-1:0] o_x,
    output logic [BLOCK_COORD_W-1:0] o_y
);

    bank_state_t              r_state;
    logic [BLOCK_COORD_W-1:0] r_x;
    logic [BLOCK_COORD_W-1:0] r_y;

    // Load only hits an EMPTY bank and release only a READING one, so the
    // three controls never collide on the same slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the coordinate registers are reset too, so RdBlockX/Y read 0
            // out of reset instead of whatever the flops powered up with.
            r_state <= BANK_EMPTY;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_state <= BANK_FULL;
            r_x     <= i_x;
            r_y     <= i_y;
        end else if (i_start) begin
            r_state <= BANK_READING;
        end else if (i_release) begin
            r_state <= BANK_EMPTY;
        end
    end

    assign o_state = r_state;
    assign o_x     = r_x;
    assign o_y     = r_y;

endmodule

// File: rtl/jpeg_ycbcr_bank_ctrl.sv
// Ping-pong bank controller between the MCU writer and the YCbCr converter.
// Define JPEG_BANKCTRL_ERR_EN to build the sticky Overflow error detector.
module jpeg_ycbcr_bank_ctrl
    import jpeg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    output logic                     WrReady,
    output logic                     WrBank,
    input  logic                     WrDone,
    input  logic [BLOCK_COORD_W-1:0] WrBlockX,
    input  logic [BLOCK_COORD_W-1:0] WrBlockY,
    output logic                     RdEnable,
    output logic [BLOCK_COORD_W-1:0] RdBlockX,
    output logic [BLOCK_COORD_W-1:0] RdBlockY,
    output logic                     RdBank,
    input  logic                     RdRead,
    output logic [1:0]               BankFull,
    output logic                     Overflow
);

    logic                     r_wp;
    logic                     r_rp;
    logic                     r_rd_enable;
    rd_state_t                r_rd_state;
    rd_state_t                w_rd_state_nxt;
    logic                     w_start_rd;
    logic                     w_release_rd;
    logic                     w_wr_accept;
    bank_state_t              w_bank_state [2];
    logic [BLOCK_COORD_W-1:0] w_bank_x     [2];
    logic [BLOCK_COORD_W-1:0] w_bank_y     [2];

    assign WrReady     = (w_bank_state[r_wp] == BANK_EMPTY);
    assign w_wr_accept = WrDone && WrReady;

    for (genvar n = 0; n < 2; n++) begin : g_slot
        jpeg_bank_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_wr_accept  && (r_wp == 1'(n))),
            .i_x       (WrBlockX),
            .i_y       (WrBlockY),
            .i_start   (w_start_rd   && (r_rp == 1'(n))),
            .i_release (w_release_rd && (r_rp == 1'(n))),
            .o_state   (w_bank_state[n]),
            .o_x       (w_bank_x[n]),
            .o_y       (w_bank_y[n])
        );
        assign BankFull[n] = (w_bank_state[n] != BANK_EMPTY);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        w_rd_state_nxt = r_rd_state;
        w_start_rd     = 1'b0;
        w_release_rd   = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_bank_state[r_rp] == BANK_FULL) w_rd_state_nxt = R_REQ;
            end
            R_REQ: begin
                if (RdRead) begin
                    w_rd_state_nxt = R_BUSY;
                    w_start_rd     = 1'b1;
                end
            end
            R_BUSY: begin
                if (!RdRead) begin
                    w_rd_state_nxt = R_IDLE;
                    w_release_rd   = 1'b1;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state  <= R_IDLE;
            r_rd_enable <= 1'b0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
        end else begin
            r_rd_state  <= w_rd_state_nxt;
            r_rd_enable <= (w_rd_state_nxt == R_REQ);
            r_wp        <= r_wp ^ w_wr_accept;
            r_rp        <= r_rp ^ w_release_rd;
        end
    end

    assign WrBank   = r_wp;
    assign RdBank   = r_rp;
    assign RdEnable = r_rd_enable;
    assign RdBlockX = w_bank_x[r_rp];
    assign RdBlockY = w_bank_y[r_rp];

`ifdef JPEG_BANKCTRL_ERR_EN
    logic r_rd_read_q;
    logic r_overflow;

    // Flags a write into an occupied bank, or a converter start nobody asked for.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_read_q <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rd_read_q <= RdRead;
            if ((WrDone && !WrReady) ||
                (RdRead && !r_rd_read_q && (r_rd_state != R_REQ))) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign Overflow = r_overflow;
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_ycbcr_bank_ctrl.sv
// Scoreboard bench for jpeg_ycbcr_bank_ctrl: writer pushes expected blocks,
// a monitor pops and compares each time the controller offers a block.
module tb_jpeg_ycbcr_bank_ctrl;

`ifdef JPEG_BANKCTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WrReady;
    logic        WrBank;
    logic        WrDone = 1'b0;
    logic [11:0] WrBlockX = '0;
    logic [11:0] WrBlockY = '0;
    logic        RdEnable;
    logic [11:0] RdBlockX;
    logic [11:0] RdBlockY;
    logic        RdBank;
    logic        RdRead = 1'b0;
    logic [1:0]  BankFull;
    logic        Overflow;

    jpeg_ycbcr_bank_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .WrReady  (WrReady),
        .WrBank   (WrBank),
        .WrDone   (WrDone),
        .WrBlockX (WrBlockX),
        .WrBlockY (WrBlockY),
        .RdEnable (RdEnable),
        .RdBlockX (RdBlockX),
        .RdBlockY (RdBlockY),
        .RdBank   (RdBank),
        .RdRead   (RdRead),
        .BankFull (BankFull),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        bank;
    } blk_t;

    blk_t exp_q[$];
    logic model_wp   = 1'b0;
    int   errors     = 0;
    int   checks     = 0;
    int   reads_seen = 0;
    int   bursts     = 0;
    bit   conv_stall = 1'b0;
    bit   gap_chk    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Converter model: starts a 256-cycle burst as soon as it sees a request.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                RdRead = 1'b0;
                cnt    = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) RdRead = 1'b0;
            end else if (RdEnable && !conv_stall) begin
                RdRead = 1'b1;
                cnt    = 256;
            end
        end
    end

    // Monitor: each new request must offer the oldest outstanding block.
    initial begin
        logic prev_en  = 1'b0;
        logic prev_rd  = 1'b0;
        int   low_run  = 0;
        blk_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (RdEnable && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_block_x", RdBlockX, e.x);
                        check("rd_block_y", RdBlockY, e.y);
                        check("rd_bank", RdBank, e.bank);
                        reads_seen++;
                    end
                end
                if (RdEnable && RdRead && prev_rd) check("rd_enable_during_read", 1, 0);
                if (RdRead) begin
                    if (!prev_rd && gap_chk) begin
                        if (bursts > 0) check("rd_gap", low_run, 2);
                        bursts++;
                    end
                    low_run = 0;
                end else begin
                    low_run++;
                end
            end
            prev_en = RdEnable;
            prev_rd = RdRead;
        end
    end

    task automatic write_block(input logic [11:0] x, input logic [11:0] y);
        int n = 0;
        blk_t b;
        @(negedge clk);
        while (!WrReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!WrReady) begin
            check("wr_ready_timeout", 0, 1);
            return;
        end
        check("wr_bank", WrBank, model_wp);
        WrDone   = 1'b1;
        WrBlockX = x;
        WrBlockY = y;
        b.x = x;
        b.y = y;
        b.bank = model_wp;
        exp_q.push_back(b);
        model_wp = ~model_wp;
        @(posedge clk);
        #1 WrDone = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((BankFull != 2'b00 || RdRead) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", BankFull, 2'b00);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {WrReady, WrBank, RdEnable, RdBank, BankFull, Overflow}, 7'b1000000);
        check({name, "_coord"}, {RdBlockX, RdBlockY}, 24'h0);
    endtask

    initial begin
        int n;
        int base;
        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_reset_outputs("idle_after_reset");
        end

        // First block: occupancy, then request with its coordinates
        write_block(12'd3, 12'd5);
        @(negedge clk);
        check("first_bankfull", BankFull, 2'b01);
        check("first_wrbank", WrBank, 1'b1);
        check("first_rdenable_early", RdEnable, 1'b0);
        @(negedge clk);
        check("first_rdenable", RdEnable, 1'b1);
        check("first_rd_coord", {RdBlockX, RdBlockY, RdBank}, {12'd3, 12'd5, 1'b0});
        @(negedge clk);
        check("rdenable_drop", {RdEnable, RdRead}, 2'b01);
        n = 0;
        while (RdRead && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("read_fall_timeout", RdRead, 1'b0);
        check("bank0_still_busy", BankFull, 2'b01);
        @(negedge clk);
        check("bank0_released", {BankFull, RdBank, WrReady}, 4'b0011);

        // Reader stalled: both banks fill, a third write is dropped
        conv_stall = 1'b1;
        write_block(12'd1, 12'd0);
        write_block(12'd2, 12'd0);
        @(negedge clk);
        check("both_full", {WrReady, BankFull}, 3'b011);
        WrDone = 1'b1;
        WrBlockX = 12'd9;
        WrBlockY = 12'd9;
        @(posedge clk);
        #1 WrDone = 1'b0;
        @(negedge clk);
        check("drop_bankfull", BankFull, 2'b11);
        check("drop_wrbank", WrBank, model_wp);
        check("drop_coord", {RdBlockX, RdBlockY}, {12'd1, 12'd0});
        check("overflow", Overflow, ERR_EN);
        conv_stall = 1'b0;
        wait_drain();

        // Back-to-back stream of eight blocks
        base    = reads_seen;
        bursts  = 0;
        gap_chk = 1'b1;
        for (int i = 0; i < 8; i++) write_block(12'(i), 12'($urandom_range(0, 4095)));
        wait_drain();
        gap_chk = 1'b0;
        check("stream_reads", reads_seen - base, 8);
        check("stream_bursts", bursts, 8);

        // Random blocks with random idle time between writes
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            write_block(12'($urandom), 12'($urandom));
        end
        wait_drain();

        // Reset in the middle of a read
        write_block(12'($urandom), 12'($urandom));
        n = 0;
        while (!RdRead && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("read_start_timeout", RdRead, 1'b1);
        repeat (100) @(negedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_wp = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        write_block(12'h7AB, 12'h0CD);
        wait_drain();
        check("queue_empty", exp_q.size(), 0);
        check("total_reads", reads_seen, 1 + 2 + 8 + 6 + 1 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jpeg_ycbcr_bank_ctrl.md
JPEG_YCBCR_BANK_CTRL -- requirements
Module: jpeg_ycbcr_bank_ctrl

Interface
REQ-001 Ports SHALL be rst and clk: one clock; reset is asynchronous and active-low (rst low clears state at once, clk rising edge for all state).
REQ-002 rst  in  1  asynchronous active-low reset.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 WrReady  out  1  bank at write pointer is EMPTY; writer may fill it.
REQ-005 WrBank  out  1  bank index the writer fills (MSB of the 16x16 MCU buffer write address).
REQ-006 WrDone  in  1  one-cycle pulse: current write bank fully loaded.
REQ-007 WrBlockX/WrBlockY  in  12 each  MCU coordinates of the block just written, valid with WrDone.
REQ-008 RdEnable  out  1  start request to the colour converter (drives its InEnable).
REQ-009 RdBlockX/RdBlockY  out  12 each  coordinates of the bank being offered/read.
REQ-010 RdBank  out  1  bank index for the converter's read address MSB.
REQ-011 RdRead  in  1  converter busy flag (its InRead), high for exactly 256 cycles per block.
REQ-012 BankFull  out  2  bit n set when bank n is FULL or READING.
REQ-013 Overflow  out  1  sticky error flag (see Configuration).

Function
REQ-014 Each bank SHALL hold state EMPTY, FULL or READING plus a registered 12-bit X/Y pair.
REQ-015 WrReady SHALL be 1 exactly when bank[wp] is EMPTY; WrBank SHALL equal wp.
REQ-016 WrDone with WrReady=1 SHALL, next edge, set bank[wp]=FULL, latch WrBlockX/Y into bank[wp], and toggle wp.
REQ-017 WrDone with WrReady=0 SHALL change no bank state, no pointer and no stored coordinates.
REQ-018 Reader FSM SHALL have states R_IDLE, R_REQ, R_BUSY; rp selects the bank; RdBank=rp; RdBlockX/Y = coordinates of bank[rp].
REQ-019 R_IDLE: if bank[rp]==FULL, next edge SHALL set RdEnable=1 and go to R_REQ; otherwise stay.
REQ-020 R_REQ: hold RdEnable=1 until RdRead==1; on that edge SHALL clear RdEnable, set bank[rp]=READING, go to R_BUSY.
REQ-021 R_BUSY: when RdRead==0, next edge SHALL set bank[rp]=EMPTY, toggle rp, go to R_IDLE.
REQ-022 Latency: bank FULL to RdEnable high = 1 cycle; RdRead fall to bank EMPTY (WrReady high if wp==rp) = 1 cycle.
REQ-023 Simultaneous WrDone into bank A and release of bank B SHALL both take effect on the same edge; WrDone completing bank[rp] while in R_IDLE SHALL be seen by the reader on the following cycle.
REQ-024 Pointers SHALL wrap 1->0; at most two blocks outstanding; banks are consumed strictly in write order.
REQ-025 RdEnable SHALL never be high while RdRead is high for more than one cycle.

Reset
REQ-026 While rst=0: both banks EMPTY, wp=rp=0, reader R_IDLE, stored coordinates 0.
REQ-027 Reset outputs: WrReady=1, WrBank=0, RdEnable=0, RdBank=0, RdBlockX/Y=0, BankFull=00, Overflow=0.
REQ-028 Reset mid-block SHALL discard all bank contents; RdRead activity after reset is ignored until a bank becomes FULL.

Configuration
REQ-029 Macro JPEG_BANKCTRL_ERR_EN defined: Overflow SHALL set on any WrDone with WrReady=0, and on RdRead rising while not in R_REQ; it clears only on reset.
REQ-030 Macro undefined: Overflow SHALL be constant 0 and no error logic synthesised; all other behaviour identical.

Structure
REQ-031 Shared package jpeg_pkg SHALL hold the bank-state encoding (EMPTY/FULL/READING), reader-state encoding, and BLOCK_COORD_W=12.
REQ-032 One sub-module jpeg_bank_slot (state plus coordinate register per bank, instantiated twice) is natural; the FSM stays at top level.

Verification
REQ-033 Reset, then idle: WrReady=1, WrBank=0, RdEnable=0, BankFull=00 for 10 cycles.
REQ-034 WrDone X=3,Y=5 -> BankFull=01, WrBank=1 next cycle; RdEnable=1 one cycle later with RdBlockX=3, RdBlockY=5, RdBank=0.
REQ-035 Converter model raises RdRead for 256 cycles -> RdEnable drops after first RdRead cycle; bank 0 EMPTY and RdBank=1 one cycle after RdRead falls.
REQ-036 Two WrDone (X=1,Y=0; X=2,Y=0) with reader stalled -> WrReady=0, BankFull=11; third WrDone ignored, Overflow=1 only with JPEG_BANKCTRL_ERR_EN.
REQ-037 Back-to-back stream of 8 blocks (X=0..7) -> converter sees X order 0..7, no block lost or repeated, gap between RdRead bursts of 2 cycles.
REQ-038 rst asserted at cycle 100 of a 256-cycle read -> all outputs at reset values immediately; next block after reset reads from bank 0.
